mips_multicycle_control: RTL and testbench

- Main control unit of the multi-cycle MIPS core; sits directly upstream of the unified instruction/data memory.
- Sequences every instruction through Fetch/Decode/Execute/Memory/Writeback.
- Drives the memory write enable, the address-source select (PC vs ALUOut), register/ALU/PC strobes and ALU control.
- Carries a retired-instruction counter for bring-up visibility.

---
 rtl/mips_ctrl_pkg.sv | 43 ++++
 rtl/mips_multicycle_control_alu_dec.sv | 34 +++
 rtl/mips_multicycle_control.sv | 164 ++++++++++++++++
 tb/tb_mips_multicycle_control.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM states, opcodes,
// funct codes, ALUOp and ALUControl values.
package mips_ctrl_pkg;

   typedef logic [3:0] state_t;

   localparam state_t S_FETCH    = 4'd0;
   localparam state_t S_DECODE   = 4'd1;
   localparam state_t S_MEMADR   = 4'd2;
   localparam state_t S_MEMREAD  = 4'd3;
   localparam state_t S_MEMWB    = 4'd4;
   localparam state_t S_MEMWRITE = 4'd5;
   localparam state_t S_EXECUTE  = 4'd6;
   localparam state_t S_ALUWB    = 4'd7;
   localparam state_t S_BRANCH   = 4'd8;
   localparam state_t S_ADDIEXEC = 4'd9;
   localparam state_t S_ADDIWB   = 4'd10;
   localparam state_t S_JUMP     = 4'd11;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mips_multicycle_control_alu_dec.sv
// Combinational ALU decoder: ALUOp and Funct select the ALUControl code.
// funct_illegal_o flags an unsupported Funct regardless of ALUOp.
module mips_alu_decoder
   import mips_ctrl_pkg::*;
(
   input  logic [1:0] alu_op_i,
   input  logic [5:0] funct_i,
   output logic [2:0] alu_control_o,
   output logic       funct_illegal_o
);

   logic [2:0] fn_ctl;

   always_comb begin
      fn_ctl          = ALU_ADD;
      funct_illegal_o = 1'b1;
      case (funct_i)
         FN_ADD: begin fn_ctl = ALU_ADD; funct_illegal_o = 1'b0; end
         FN_SUB: begin fn_ctl = ALU_SUB; funct_illegal_o = 1'b0; end
         FN_AND: begin fn_ctl = ALU_AND; funct_illegal_o = 1'b0; end
         FN_OR:  begin fn_ctl = ALU_OR;  funct_illegal_o = 1'b0; end
         FN_SLT: begin fn_ctl = ALU_SLT; funct_illegal_o = 1'b0; end
         default: ;
      endcase

      case (alu_op_i)
         ALUOP_ADD:   alu_control_o = ALU_ADD;
         ALUOP_SUB:   alu_control_o = ALU_SUB;
         ALUOP_FUNCT: alu_control_o = fn_ctl;
         default:     alu_control_o = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mips_multicycle_control.sv
// Moore control FSM of the multi-cycle MIPS core with a retired-instruction
// counter; dbg_state exposes the current state for bring-up.
module mips_multicycle_control
   import mips_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       Op,
   input  logic [5:0]       Funct,
   input  logic             Zero,
   output logic             MemWrite,
   output logic             IorD,
   output logic             IRWrite,
   output logic             RegDst,
   output logic             MemtoReg,
   output logic             RegWrite,
   output logic             ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       PCSrc,
   output logic             PCEn,
   output logic [2:0]       ALUControl,
   output logic             illegal_op,
   output logic [CNT_W-1:0] instr_count,
   output logic [3:0]       dbg_state
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic       mem_write, iord, ir_write, reg_dst, mem_to_reg, reg_write;
   logic       src_a, pc_write, branch, illegal, retire;
   logic [1:0] src_b, pc_src, alu_op;
   logic [2:0] alu_ctl;
   logic       funct_illegal;

   mips_alu_decoder u_alu_dec (
      .alu_op_i        (alu_op),
      .funct_i         (Funct),
      .alu_control_o   (alu_ctl),
      .funct_illegal_o (funct_illegal)
   );

   // Unlisted and unreachable states fall through with every strobe at 0.
   always_comb begin
      state_d    = S_FETCH;
      mem_write  = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      src_a      = 1'b0;
      src_b      = 2'b00;
      pc_src     = 2'b00;
      pc_write   = 1'b0;
      branch     = 1'b0;
      alu_op     = ALUOP_ADD;
      illegal    = 1'b0;
      retire     = 1'b0;
      case (state_q)
         S_FETCH: begin
            ir_write = 1'b1;
            src_b    = 2'b01;
            pc_write = 1'b1;
            state_d  = S_DECODE;
         end
         S_DECODE: begin
            src_b = 2'b11;
            case (Op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE: begin
                  state_d = S_EXECUTE;
                  illegal = funct_illegal;
               end
               OP_BEQ:  state_d = S_BRANCH;
               OP_ADDI: state_d = S_ADDIEXEC;
               OP_J:    state_d = S_JUMP;
               default: illegal = 1'b1;
            endcase
         end
         S_MEMADR: begin
            src_a   = 1'b1;
            src_b   = 2'b10;
            state_d = (Op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            iord    = 1'b1;
            state_d = S_MEMWB;
         end
         S_MEMWB: begin
            mem_to_reg = 1'b1;
            reg_write  = 1'b1;
            retire     = 1'b1;
         end
         S_MEMWRITE: begin
            iord      = 1'b1;
            mem_write = 1'b1;
            retire    = 1'b1;
         end
         S_EXECUTE: begin
            src_a   = 1'b1;
            alu_op  = ALUOP_FUNCT;
            state_d = S_ALUWB;
         end
         S_ALUWB: begin
            reg_dst   = 1'b1;
            reg_write = 1'b1;
            retire    = 1'b1;
         end
         S_BRANCH: begin
            src_a  = 1'b1;
            alu_op = ALUOP_SUB;
            branch = 1'b1;
            pc_src = 2'b01;
            retire = 1'b1;
         end
         S_ADDIEXEC: begin
            src_a   = 1'b1;
            src_b   = 2'b10;
            state_d = S_ADDIWB;
         end
         S_ADDIWB: begin
            reg_write = 1'b1;
            retire    = 1'b1;
         end
         S_JUMP: begin
            pc_src   = 2'b10;
            pc_write = 1'b1;
            retire   = 1'b1;
         end
         default: ;
      endcase
      cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // The reset state is FETCH, whose strobes must not reach memory or PC while held.
   assign MemWrite    = rst_n & mem_write;
   assign IorD        = rst_n & iord;
   assign IRWrite     = rst_n & ir_write;
   assign RegDst      = rst_n & reg_dst;
   assign MemtoReg    = rst_n & mem_to_reg;
   assign RegWrite    = rst_n & reg_write;
   assign ALUSrcA     = rst_n & src_a;
   assign ALUSrcB     = rst_n ? src_b : 2'b00;
   assign PCSrc       = rst_n ? pc_src : 2'b00;
   assign PCEn        = rst_n & (pc_write | (branch & Zero));
   assign ALUControl  = rst_n ? alu_ctl : 3'b000;
   assign illegal_op  = rst_n & illegal;
   assign instr_count = cnt_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Randomized scoreboard bench for mips_multicycle_control: a per-instruction
// reference model pushes one expected output vector per cycle; a monitor pops them.
module tb_mips_multicycle_control;
   import mips_ctrl_pkg::*;

   localparam int CNT_W = 8;
   localparam int VW    = 20 + CNT_W;

   localparam int C_LW = 0, C_SW = 1, C_R = 2, C_BEQ = 3, C_ADDI = 4, C_J = 5, C_ILL = 6;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [5:0]       Op, Funct;
   logic             Zero;
   logic             MemWrite, IorD, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
   logic [1:0]       ALUSrcB, PCSrc;
   logic             PCEn, illegal_op;
   logic [2:0]       ALUControl;
   logic [CNT_W-1:0] instr_count;
   logic [3:0]       dbg_state;

   always #5 clk = ~clk;

   mips_multicycle_control #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .Op(Op), .Funct(Funct), .Zero(Zero),
      .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite), .RegDst(RegDst),
      .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .PCSrc(PCSrc), .PCEn(PCEn), .ALUControl(ALUControl), .illegal_op(illegal_op),
      .instr_count(instr_count), .dbg_state(dbg_state)
   );

   logic [VW-1:0]    exp_q[$];
   string            tag_q[$];
   int               checks = 0;
   int               errors = 0;
   logic [CNT_W-1:0] model_cnt = '0;
   bit               mon_en = 1'b0;
   logic [5:0]       fn_tab[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

   task automatic check(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [VW-1:0] act_vec();
      return {dbg_state, MemWrite, IorD, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
              ALUSrcB, PCSrc, PCEn, ALUControl, illegal_op, instr_count};
   endfunction

   task automatic push_exp(input string nm, input logic [3:0] st,
                           input logic mw, input logic iord, input logic irw, input logic rdst,
                           input logic m2r, input logic rw, input logic sa,
                           input logic [1:0] sb, input logic [1:0] pcs, input logic pce,
                           input logic [2:0] alu, input logic ill);
      exp_q.push_back({st, mw, iord, irw, rdst, m2r, rw, sa, sb, pcs, pce, alu, ill, model_cnt});
      tag_q.push_back(nm);
   endtask

   task automatic push_reset(input string nm);
      exp_q.push_back({S_FETCH, 16'h0000, {CNT_W{1'b0}}});
      tag_q.push_back(nm);
   endtask

   function automatic int classify(input logic [5:0] op);
      case (op)
         6'b100011: return C_LW;
         6'b101011: return C_SW;
         6'b000000: return C_R;
         6'b000100: return C_BEQ;
         6'b001000: return C_ADDI;
         6'b000010: return C_J;
         default:   return C_ILL;
      endcase
   endfunction

   function automatic logic funct_ok(input logic [5:0] fn);
      foreach (fn_tab[i]) if (fn_tab[i] == fn) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [2:0] rtype_alu(input logic [5:0] fn);
      case (fn)
         6'b100000: return 3'b010;
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b010;
      endcase
   endfunction

   function automatic int latency(input int cls);
      case (cls)
         C_LW: return 5;
         C_SW, C_R, C_ADDI: return 4;
         C_BEQ, C_J: return 3;
         default: return 2;
      endcase
   endfunction

   task automatic push_instr(input string nm, input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input int cls);
      logic ill;
      ill = (cls == C_ILL) || (cls == C_R && !funct_ok(fn));
      push_exp({nm, "/fetch"}, S_FETCH, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
               2'b01, 2'b00, 1'b1, 3'b010, 1'b0);
      push_exp({nm, "/decode"}, S_DECODE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
               2'b11, 2'b00, 1'b0, 3'b010, ill);
      case (cls)
         C_LW, C_SW: begin
            push_exp({nm, "/memadr"}, S_MEMADR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                     2'b10, 2'b00, 1'b0, 3'b010, 1'b0);
            if (cls == C_LW) begin
               push_exp({nm, "/memread"}, S_MEMREAD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                        2'b00, 2'b00, 1'b0, 3'b010, 1'b0);
               push_exp({nm, "/memwb"}, S_MEMWB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
                        2'b00, 2'b00, 1'b0, 3'b010, 1'b0);
            end else
               push_exp({nm, "/memwrite"}, S_MEMWRITE, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                        2'b00, 2'b00, 1'b0, 3'b010, 1'b0);
         end
         C_R: begin
            push_exp({nm, "/execute"}, S_EXECUTE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                     2'b00, 2'b00, 1'b0, rtype_alu(fn), 1'b0);
            push_exp({nm, "/aluwb"}, S_ALUWB, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
                     2'b00, 2'b00, 1'b0, 3'b010, 1'b0);
         end
         C_BEQ:
            push_exp({nm, "/branch"}, S_BRANCH, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                     2'b00, 2'b01, z, 3'b110, 1'b0);
         C_ADDI: begin
            push_exp({nm, "/addiexec"}, S_ADDIEXEC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                     2'b10, 2'b00, 1'b0, 3'b010, 1'b0);
            push_exp({nm, "/addiwb"}, S_ADDIWB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                     2'b00, 2'b00, 1'b0, 3'b010, 1'b0);
         end
         C_J:
            push_exp({nm, "/jump"}, S_JUMP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                     2'b00, 2'b10, 1'b1, 3'b010, 1'b0);
         default: ;
      endcase
   endtask

   // Called one tick after the edge that enters FETCH; returns at the same point of the next FETCH.
   task automatic run_instr(input string nm, input logic [5:0] op, input logic [5:0] fn,
                            input logic z);
      int cls;
      cls   = classify(op);
      Op    = op;
      Funct = fn;
      Zero  = z;
      push_instr(nm, op, fn, z, cls);
      if (cls != C_ILL) model_cnt = model_cnt + 1'b1;
      repeat (latency(cls)) @(posedge clk);
      #1;
   endtask

   task automatic sw_with_reset();
      Op    = 6'b101011;
      Funct = 6'b000100;
      Zero  = 1'b0;
      push_instr("sw_rst", Op, Funct, Zero, C_SW);
      void'(exp_q.pop_back());
      void'(tag_q.pop_back());
      push_reset("sw_rst/held1");
      push_reset("sw_rst/held2");
      repeat (3) @(posedge clk);
      #1;
      check("sw_rst_memwrite_before", VW'(MemWrite), VW'(1'b1));
      #2 rst_n = 1'b0;
      #1;
      check("sw_rst_memwrite_async", VW'(MemWrite), VW'(1'b0));
      check("sw_rst_state_async", VW'(dbg_state), VW'(S_FETCH));
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      model_cnt = '0;
   endtask

   always @(negedge clk) begin
      logic [VW-1:0] e;
      string         t;
      if (mon_en) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL monitor_underflow: got an output cycle, expected none queued");
         end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(t, act_vec(), e);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion within 200000 time units, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      int         r;
      logic [5:0] op, fn;
      rst_n = 1'b0;
      Op    = 6'b000000;
      Funct = 6'b000000;
      Zero  = 1'b0;
      @(posedge clk);
      #1;
      push_reset("reset");
      mon_en = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      run_instr("addi", 6'b001000, 6'b000101, 1'b0);
      run_instr("lw", 6'b100011, 6'b010000, 1'b0);
      run_instr("sw", 6'b101011, 6'b000100, 1'b1);
      run_instr("beq_z1", 6'b000100, 6'b000011, 1'b1);
      run_instr("beq_z0", 6'b000100, 6'b000011, 1'b0);
      run_instr("r_or", 6'b000000, 6'b100101, 1'b0);
      run_instr("r_badfn", 6'b000000, 6'b111111, 1'b0);
      run_instr("ill_op", 6'b111111, 6'b000000, 1'b0);
      run_instr("j", 6'b000010, 6'b001001, 1'b1);
      sw_with_reset();
      run_instr("addi_after_rst", 6'b001000, 6'b000001, 1'b0);

      for (int i = 0; i < 300; i++) begin
         r  = $urandom_range(0, 9);
         fn = 6'($urandom_range(0, 63));
         case (r)
            0: op = 6'b100011;
            1: op = 6'b101011;
            2, 3: begin
               op = 6'b000000;
               fn = fn_tab[$urandom_range(0, 4)];
            end
            4: op = 6'b000100;
            5: op = 6'b001000;
            6: op = 6'b000010;
            8: op = 6'b000000;
            default: op = 6'($urandom_range(0, 63));
         endcase
         run_instr($sformatf("rnd%0d", i), op, fn, 1'($urandom_range(0, 1)));
      end

      check("queue_drained", VW'(exp_q.size()), VW'(0));
      mon_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
